// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: FETCH/DECODE/EXEC_MEM/HALT with a memory req/ack handshake.
// Strobes are combinational from state, latched opcode, mem_ack and ACC flags.
module mu0_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_ack,
    input  logic [3:0]         mem_rdata_op,
    input  logic               acc_zero,
    input  logic               acc_neg,
    output logic               mem_req,
    output logic               mem_wr,
    output logic               addr_sel,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               acc_load,
    output logic [1:0]         alu_op,
    output logic               fetch,
    output logic               exec1,
    output logic               exec2,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t             state;
    logic [3:0]         op;
    logic               illegal_q;
    logic [COUNT_W-1:0] count_q;

    // Reset masks every output so an in-flight access is dropped in the reset cycle.
    always_comb begin
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        addr_sel    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        acc_load    = 1'b0;
        alu_op      = 2'b00;
        fetch       = 1'b0;
        exec1       = 1'b0;
        exec2       = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        instr_count = '0;
        if (!reset) begin
            illegal     = illegal_q;
            instr_count = count_q;
            case (state)
                S_FETCH: begin
                    fetch   = 1'b1;
                    mem_req = 1'b1;
                    ir_load = mem_ack;
                    pc_inc  = mem_ack;
                end
                S_DECODE: begin
                    exec1 = 1'b1;
                    case (op)
                        OP_JMP:  pc_load = 1'b1;
                        OP_JGE:  pc_load = ~acc_neg;
                        OP_JNE:  pc_load = ~acc_zero;
                        default: pc_load = 1'b0;
                    endcase
                end
                S_EXEC: begin
                    exec2    = 1'b1;
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_wr   = (op == OP_STO);
                    if (mem_ack) begin
                        case (op)
                            OP_LDA: begin acc_load = 1'b1; alu_op = 2'b00; end
                            OP_ADD: begin acc_load = 1'b1; alu_op = 2'b01; end
                            OP_SUB: begin acc_load = 1'b1; alu_op = 2'b10; end
                            default: acc_load = 1'b0;
                        endcase
                    end
                end
                default: halted = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op        <= 4'd0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        op    <= mem_rdata_op;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op[3]) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        case (op)
                            OP_LDA, OP_STO, OP_ADD, OP_SUB: state <= S_EXEC;
                            OP_STP: begin
                                state   <= S_HALT;
                                count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                            end
                            default: begin
                                // Jumps retire here whether taken or not.
                                state   <= S_FETCH;
                                count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (mem_ack) begin
                        state   <= S_FETCH;
                        count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed-vector bench: each stimulus cycle queues its hand-computed expected outputs,
// and an independent negedge monitor pops and compares them.
module tb_mu0_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_ack = 1'b0;
    logic [3:0]    mem_rdata_op = 4'd0;
    logic          acc_zero = 1'b0;
    logic          acc_neg = 1'b0;
    logic          mem_req, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load;
    logic [1:0]    alu_op;
    logic          fetch, exec1, exec2, halted, illegal;
    logic [CW-1:0] instr_count;

    mu0_sequencer #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mem_ack(mem_ack), .mem_rdata_op(mem_rdata_op),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_req(mem_req), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .acc_load(acc_load), .alu_op(alu_op), .fetch(fetch), .exec1(exec1),
        .exec2(exec2), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op,
    //  fetch, exec1, exec2, halted, illegal, instr_count}
    logic [13+CW:0] exp_q[$];
    string          name_q[$];
    int             vectors = 0;
    int             miscompares = 0;

    function automatic logic [13:0] vr();
        return 14'b0;
    endfunction
    function automatic logic [13:0] vf(input logic a);
        return {1'b1, 1'b0, 1'b0, a, a, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [13:0] vd(input logic pcl);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcl, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [13:0] ve(input logic wr, input logic al, input logic [1:0] op);
        return {1'b1, wr, 1'b1, 1'b0, 1'b0, 1'b0, al, op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic logic [13:0] vh(input logic ill);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ill};
    endfunction

    task automatic step(input logic rst, input logic ack, input logic [3:0] rop,
                        input logic az, input logic an, input logic [13:0] e,
                        input int cnt, input string nm);
        @(posedge clk);
        #1;
        reset        = rst;
        mem_ack      = ack;
        mem_rdata_op = rop;
        acc_zero     = az;
        acc_neg      = an;
        exp_q.push_back({e, CW'(cnt)});
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13+CW:0] act, expv;
            string nm;
            act = {mem_req, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op,
                   fetch, exec1, exec2, halted, illegal, instr_count};
            expv = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL %s: got %b required %b", nm, act, expv);
            end
        end
    end

    initial begin
        // Reset state
        step(1, 0, 4'h0, 0, 0, vr(), 0, "reset0");
        step(1, 1, 4'h0, 0, 0, vr(), 0, "reset1");
        // Zero-wait program: LDA, ADD, STO, STP (11 cycles to HALT)
        step(0, 1, 4'h0, 0, 0, vf(1), 0, "lda_fetch");
        step(0, 0, 4'h0, 0, 0, vd(0), 0, "lda_decode");
        step(0, 1, 4'h0, 0, 0, ve(0, 1, 2'b00), 0, "lda_exec");
        step(0, 1, 4'h2, 0, 0, vf(1), 1, "add_fetch");
        step(0, 0, 4'h0, 0, 0, vd(0), 1, "add_decode");
        step(0, 1, 4'h0, 0, 0, ve(0, 1, 2'b01), 1, "add_exec");
        step(0, 1, 4'h1, 0, 0, vf(1), 2, "sto_fetch");
        step(0, 0, 4'h0, 0, 0, vd(0), 2, "sto_decode");
        step(0, 1, 4'h0, 0, 0, ve(1, 0, 2'b00), 2, "sto_exec");
        step(0, 1, 4'h7, 0, 0, vf(1), 3, "stp_fetch");
        step(0, 0, 4'h0, 0, 0, vd(0), 3, "stp_decode");
        step(0, 1, 4'h0, 0, 0, vh(0), 4, "halt_stp");
        step(0, 1, 4'h3, 1, 1, vh(0), 4, "halt_stp_hold");
        // Fetch wait states, then conditional jumps
        step(1, 0, 4'h0, 0, 0, vr(), 0, "reset2");
        for (int i = 0; i < 3; i++) step(0, 0, 4'h5, 0, 0, vf(0), 0, "fetch_wait");
        step(0, 1, 4'h5, 0, 0, vf(1), 0, "jge_fetch_ack");
        step(0, 0, 4'h0, 0, 1, vd(0), 0, "jge_neg");
        step(0, 1, 4'h5, 0, 1, vf(1), 1, "jge2_fetch");
        step(0, 0, 4'h0, 0, 0, vd(1), 1, "jge_pos");
        step(0, 1, 4'h6, 0, 0, vf(1), 2, "jne_fetch");
        step(0, 0, 4'h0, 1, 0, vd(0), 2, "jne_zero");
        step(0, 1, 4'h6, 1, 0, vf(1), 3, "jne2_fetch");
        step(0, 0, 4'h0, 0, 0, vd(1), 3, "jne_nonzero");
        step(0, 1, 4'h4, 0, 0, vf(1), 4, "jmp_fetch");
        step(0, 0, 4'h0, 1, 1, vd(1), 4, "jmp_decode");
        // Illegal opcode: halts, sticky flag, no count
        step(0, 1, 4'hA, 0, 0, vf(1), 5, "ill_fetch");
        step(0, 1, 4'h0, 0, 0, vd(0), 5, "ill_decode");
        step(0, 1, 4'h0, 0, 0, vh(1), 5, "ill_halt");
        step(0, 1, 4'h2, 0, 0, vh(1), 5, "ill_halt_ack");
        // Reset during a pending STO access
        step(1, 0, 4'h0, 0, 0, vr(), 0, "reset3");
        step(0, 1, 4'h1, 0, 0, vf(1), 0, "sto2_fetch");
        step(0, 0, 4'h0, 0, 0, vd(0), 0, "sto2_decode");
        step(0, 0, 4'h0, 0, 0, ve(1, 0, 2'b00), 0, "sto2_wait");
        step(1, 1, 4'h0, 0, 0, vr(), 0, "reset_mid_sto");
        step(0, 0, 4'h0, 0, 0, vf(0), 0, "fetch_after_abort");
        // 17 JMPs with a 4-bit counter: wraps 15 -> 0, ends at 1
        step(0, 0, 4'h0, 0, 0, vf(0), 0, "fetch_idle");
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 4'h4, 0, 0, vf(1), i % 16, "wrap_fetch");
            step(0, 0, 4'h0, 0, 0, vd(1), i % 16, "wrap_decode");
        end
        step(0, 0, 4'h0, 0, 0, vf(0), 1, "wrap_final");
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
